// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for the 5-stage MIPS pipeline.
// Optional hazard performance counters are enabled with `define HAZARD_PERF_EN.
module hazard_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       BranchD,
    input  logic       MemToRegE,
    input  logic       RegWriteE,
    input  logic       MemtoRegM,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    output logic       stallF,
    output logic       stallD,
    output logic       FlushE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    logic lwstall;
    logic branchstall;
    logic stall;

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        lwstall     = 1'b0;
        branchstall = 1'b0;
        stall       = 1'b0;

        if (reset) begin
            // Memory-stage result is newer, so it wins over Writeback.
            if ((RsE != 5'd0) && RegWriteM && (RsE == WriteRegM))
                ForwardAE = 2'b10;
            else if ((RsE != 5'd0) && RegWriteW && (RsE == WriteRegW))
                ForwardAE = 2'b01;

            if ((RtE != 5'd0) && RegWriteM && (RtE == WriteRegM))
                ForwardBE = 2'b10;
            else if ((RtE != 5'd0) && RegWriteW && (RtE == WriteRegW))
                ForwardBE = 2'b01;

            ForwardAD = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
            ForwardBD = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);

            lwstall = MemToRegE && ((RsD == RtE) || (RtD == RtE));
            branchstall = BranchD &&
                ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                 (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
            stall = lwstall || branchstall;
        end

        stallF = stall;
        stallD = stall;
        FlushE = stall;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q + {31'd0, stallD};
        flush_count_d = flush_count_q + {31'd0, FlushE};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    logic unused_clk;
    assign unused_clk = clk;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; counter checks run when HAZARD_PERF_EN is defined.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       BranchD, MemToRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       stallF, stallD, FlushE, ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count, flush_count;
`endif

    int total = 0;
    int bad   = 0;

    // {stallF, stallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE}
    logic [8:0] obs;
    assign obs = {stallF, stallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE};

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .BranchD(BranchD), .MemToRegE(MemToRegE), .RegWriteE(RegWriteE),
        .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .stallF(stallF), .stallD(stallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
`ifdef HAZARD_PERF_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        BranchD = 0; MemToRegE = 0; RegWriteE = 0;
        MemtoRegM = 0; RegWriteM = 0; RegWriteW = 0;
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        reset = 0; RegWriteM = 1; WriteRegM = 5; RsE = 5;
        #2;
        total++;
        if (obs !== 9'b000_00_00_00) begin
            bad++; $display("FAIL reset_hold: got %b want %b", obs, 9'b000_00_00_00);
        end
        reset = 1;
        #1;
        total++;
        if (obs !== 9'b000_00_10_00) begin
            bad++; $display("FAIL reset_release: got %b want %b", obs, 9'b000_00_10_00);
        end
    endtask

    task automatic test_no_hazard();
        @(negedge clk);
        clear_inputs();
        RsD = 1; RtD = 2; RsE = 3; RtE = 4;
        #2;
        total++;
        if (obs !== 9'b000_00_00_00) begin
            bad++; $display("FAIL no_hazard: got %b want %b", obs, 9'b000_00_00_00);
        end
        RegWriteM = 1; WriteRegM = 1;
        #2;
        total++;
        if (obs !== 9'b000_10_00_00) begin
            bad++; $display("FAIL forward_ad: got %b want %b", obs, 9'b000_10_00_00);
        end
        WriteRegM = 2;
        #2;
        total++;
        if (obs !== 9'b000_01_00_00) begin
            bad++; $display("FAIL forward_bd: got %b want %b", obs, 9'b000_01_00_00);
        end
        RsD = 0; RtD = 0; WriteRegM = 0;
        #2;
        total++;
        if (obs !== 9'b000_00_00_00) begin
            bad++; $display("FAIL forward_d_r0: got %b want %b", obs, 9'b000_00_00_00);
        end
    endtask

    task automatic test_lwstall();
        @(negedge clk);
        clear_inputs();
        MemToRegE = 1; RtE = 2; RsD = 2; RtD = 2;
        #2;
        total++;
        if (obs !== 9'b111_00_00_00) begin
            bad++; $display("FAIL lwstall: got %b want %b", obs, 9'b111_00_00_00);
        end
        RsD = 8; RtD = 9;
        #2;
        total++;
        if (obs !== 9'b000_00_00_00) begin
            bad++; $display("FAIL lw_no_match: got %b want %b", obs, 9'b000_00_00_00);
        end
        RsD = 0; RtD = 0; RtE = 0;
        #2;
        total++;
        if (obs !== 9'b111_00_00_00) begin
            bad++; $display("FAIL lwstall_r0: got %b want %b", obs, 9'b111_00_00_00);
        end
    endtask

    task automatic test_branchstall();
        @(negedge clk);
        clear_inputs();
        BranchD = 1; RegWriteE = 1; WriteRegE = 3; RsD = 3;
        #2;
        total++;
        if (obs !== 9'b111_00_00_00) begin
            bad++; $display("FAIL branch_e: got %b want %b", obs, 9'b111_00_00_00);
        end
        WriteRegE = 9;
        #2;
        total++;
        if (obs !== 9'b000_00_00_00) begin
            bad++; $display("FAIL branch_e_miss: got %b want %b", obs, 9'b000_00_00_00);
        end
        RegWriteE = 0; MemtoRegM = 1; WriteRegM = 4; RtD = 4;
        #2;
        total++;
        if (obs !== 9'b111_00_00_00) begin
            bad++; $display("FAIL branch_m: got %b want %b", obs, 9'b111_00_00_00);
        end
        BranchD = 0;
        #2;
        total++;
        if (obs !== 9'b000_00_00_00) begin
            bad++; $display("FAIL branch_off: got %b want %b", obs, 9'b000_00_00_00);
        end
    endtask

    task automatic test_forward_priority();
        @(negedge clk);
        clear_inputs();
        RsE = 7; WriteRegM = 7; WriteRegW = 7; RegWriteM = 1; RegWriteW = 1;
        #2;
        total++;
        if (obs !== 9'b000_00_10_00) begin
            bad++; $display("FAIL fwd_ae_m: got %b want %b", obs, 9'b000_00_10_00);
        end
        RegWriteM = 0;
        #2;
        total++;
        if (obs !== 9'b000_00_01_00) begin
            bad++; $display("FAIL fwd_ae_w: got %b want %b", obs, 9'b000_00_01_00);
        end
        RegWriteM = 1; RsE = 0;
        #2;
        total++;
        if (obs !== 9'b000_00_00_00) begin
            bad++; $display("FAIL fwd_ae_r0: got %b want %b", obs, 9'b000_00_00_00);
        end
        RtE = 9; WriteRegW = 9; WriteRegM = 7;
        #2;
        total++;
        if (obs !== 9'b000_00_00_01) begin
            bad++; $display("FAIL fwd_be_w: got %b want %b", obs, 9'b000_00_00_01);
        end
        WriteRegM = 9;
        #2;
        total++;
        if (obs !== 9'b000_00_00_10) begin
            bad++; $display("FAIL fwd_be_m: got %b want %b", obs, 9'b000_00_00_10);
        end
    endtask

    task automatic test_combined_and_async();
        @(negedge clk);
        clear_inputs();
        MemToRegE = 1; RtE = 6; RsD = 6; BranchD = 1; RegWriteE = 1; WriteRegE = 6;
        #2;
        total++;
        if (obs !== 9'b111_00_00_00) begin
            bad++; $display("FAIL lw_and_branch: got %b want %b", obs, 9'b111_00_00_00);
        end
        RsE = 6; RegWriteM = 1; WriteRegM = 6;
        #1;
        total++;
        if (obs !== 9'b111_10_10_10) begin
            bad++; $display("FAIL all_active: got %b want %b", obs, 9'b111_10_10_10);
        end
        reset = 0;
        #1;
        total++;
        if (obs !== 9'b000_00_00_00) begin
            bad++; $display("FAIL async_reset: got %b want %b", obs, 9'b000_00_00_00);
        end
        reset = 1;
        #1;
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf_counters();
        @(negedge clk);
        clear_inputs();
        reset = 0;
        #1;
        total++;
        if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
            bad++; $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_count, flush_count);
        end
        reset = 1;
        MemToRegE = 1; RtE = 2; RsD = 2;
        repeat (3) @(negedge clk);
        clear_inputs();
        RsD = 1; RtE = 2;
        repeat (2) @(negedge clk);
        total++;
        if (stall_count !== 32'd3 || flush_count !== 32'd3) begin
            bad++; $display("FAIL perf_count: got %0d/%0d want 3/3", stall_count, flush_count);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        reset = 0;
        test_reset();
        test_no_hazard();
        test_lwstall();
        test_branchstall();
        test_forward_priority();
        test_combined_and_async();
`ifdef HAZARD_PERF_EN
        test_perf_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
